// File: rtl/gomoku_ui_pkg.sv
// rtl/gomoku_ui_pkg.sv - shared button index constants and vector type for the gomoku UI
package gomoku_ui_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int NUM_BTN    = 5;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned press/level outputs
interface button_conditioner_if;
    import gomoku_ui_pkg::*;

    btn_vec_t btn_raw;
    logic     up;
    logic     down;
    logic     left;
    logic     right;
    logic     center;
    btn_vec_t held;

    modport master (output btn_raw, input up, down, left, right, center, held);
    modport slave  (input btn_raw, output up, down, left, right, center, held);

endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: 2-flop sync, debounce, press pulse, optional auto-repeat
module button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000,
    parameter int REPEAT_ALLOWED  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             repeating;
    logic             db_done;
    logic             falling;

    assign db_done = (sync2 != stable) && (db_cnt == DB_LAST);
    // A release accepted this edge must not also fire a repeat.
    assign falling = db_done && stable;
    assign level   = stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stable    <= 1'b0;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
            repeating <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;

            if (sync2 != stable) begin
                if (db_done) begin
                    stable <= sync2;
                    db_cnt <= '0;
                    pulse  <= sync2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end

            // Repeat runs only while already held, so it never overlaps the press pulse.
            if (REPEAT_ALLOWED != 0 && stable && !falling) begin
                if (rpt_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                    pulse     <= 1'b1;
                    rpt_cnt   <= '0;
                    repeating <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end else begin
                rpt_cnt   <= '0;
                repeating <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - five independent button channels feeding the game FSM
module button_conditioner
    import gomoku_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    btn_vec_t pulse;
    btn_vec_t held;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_ALLOWED  ((i == BTN_CENTER) ? 0 : REPEAT_EN)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btn_raw[i]),
            .pulse (pulse[i]),
            .level (held[i])
        );
    end

    assign bus.up     = pulse[BTN_UP];
    assign bus.down   = pulse[BTN_DOWN];
    assign bus.left   = pulse[BTN_LEFT];
    assign bus.right  = pulse[BTN_RIGHT];
    assign bus.center = pulse[BTN_CENTER];
    assign bus.held   = held;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;
    import gomoku_ui_pkg::*;

    localparam btn_vec_t V_NONE   = 5'b00000;
    localparam btn_vec_t V_UP     = btn_vec_t'(1 << BTN_UP);
    localparam btn_vec_t V_DOWN   = btn_vec_t'(1 << BTN_DOWN);
    localparam btn_vec_t V_LEFT   = btn_vec_t'(1 << BTN_LEFT);
    localparam btn_vec_t V_RIGHT  = btn_vec_t'(1 << BTN_RIGHT);
    localparam btn_vec_t V_CENTER = btn_vec_t'(1 << BTN_CENTER);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if bus ();
    button_conditioner_if bus_nr ();
    assign bus_nr.btn_raw = bus.btn_raw;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4), .REPEAT_DELAY (10), .REPEAT_PERIOD (3), .REPEAT_EN (1)
    ) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (4), .REPEAT_DELAY (10), .REPEAT_PERIOD (3), .REPEAT_EN (0)
    ) u_dut_nr (
        .clk (clk), .rst (rst), .bus (bus_nr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int pcnt  [NUM_BTN];
    int pfirst[NUM_BTN];
    int hchg  [NUM_BTN];
    int rq[$];
    int nr_cnt;
    int nr_first;
    btn_vec_t pat_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic pat(input btn_vec_t v, input int reps);
        for (int i = 0; i < reps; i++) pat_q.push_back(v);
    endtask

    function automatic int qat(input int i);
        return (i < rq.size()) ? rq[i] : -1;
    endfunction

    function automatic int sum_pulses();
        int s = 0;
        for (int i = 0; i < NUM_BTN; i++) s += pcnt[i];
        return s;
    endfunction

    // Index k = sample taken #1 after edge k; pat_q[k] is the raw value seen at edge k.
    task automatic run(input int n);
        btn_vec_t h0;
        btn_vec_t pv;
        h0 = bus.held;
        rq.delete();
        nr_cnt   = 0;
        nr_first = -1;
        for (int i = 0; i < NUM_BTN; i++) begin
            pcnt[i] = 0; pfirst[i] = -1; hchg[i] = -1;
        end
        for (int k = 0; k < n; k++) begin
            bus.btn_raw = (k < pat_q.size()) ? pat_q[k] : pat_q[pat_q.size()-1];
            @(posedge clk);
            #1;
            pv = {bus.center, bus.right, bus.left, bus.down, bus.up};
            for (int i = 0; i < NUM_BTN; i++) begin
                if (pv[i]) begin
                    if (pcnt[i] == 0) pfirst[i] = k;
                    pcnt[i]++;
                end
                if (hchg[i] < 0 && bus.held[i] != h0[i]) hchg[i] = k;
            end
            if (bus.right) rq.push_back(k);
            if (bus_nr.right) begin
                if (nr_cnt == 0) nr_first = k;
                nr_cnt++;
            end
        end
        pat_q.delete();
    endtask

    initial begin
        bus.btn_raw = V_NONE;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_held", int'(bus.held), 0);
        check("reset_pulses", int'({bus.center, bus.right, bus.left, bus.down, bus.up}), 0);
        rst = 1'b0;

        // Clean center press, held long enough that a repeat would have fired
        pat(V_CENTER, 1); run(40);
        check("clean_center_cnt", pcnt[BTN_CENTER], 1);
        check("clean_center_idx", pfirst[BTN_CENTER], 5);
        check("clean_held_rise", hchg[BTN_CENTER], 5);
        check("clean_other_pulses", sum_pulses() - pcnt[BTN_CENTER], 0);
        pat(V_NONE, 1); run(20);
        check("release_no_pulse", sum_pulses(), 0);
        check("release_held_fall", hchg[BTN_CENTER], 5);

        // Bounce on left then a short hold released before the repeat delay
        pat(V_LEFT, 1); pat(V_NONE, 1); pat(V_LEFT, 2); pat(V_NONE, 1);
        pat(V_LEFT, 7); pat(V_NONE, 1); run(30);
        check("bounce_left_cnt", pcnt[BTN_LEFT], 1);
        check("bounce_left_idx", pfirst[BTN_LEFT], 10);
        check("bounce_held_rise", hchg[BTN_LEFT], 10);

        // Auto-repeat on right: press at 5, repeats 15,18,...,33, release seen at edge 35
        pat(V_RIGHT, 30); pat(V_NONE, 1); run(50);
        check("rpt_cnt", rq.size(), 8);
        check("rpt_press", qat(0), 5);
        check("rpt_first", qat(1), 15);
        check("rpt_second", qat(2), 18);
        check("rpt_last", qat(7), 33);
        check("rpt_dis_cnt", nr_cnt, 1);
        check("rpt_dis_idx", nr_first, 5);

        // Simultaneous up + center
        pat(V_UP | V_CENTER, 1); run(12);
        check("sim_up_idx", pfirst[BTN_UP], 5);
        check("sim_center_idx", pfirst[BTN_CENTER], 5);
        check("sim_up_cnt", pcnt[BTN_UP], 1);
        check("sim_center_cnt", pcnt[BTN_CENTER], 1);
        pat(V_NONE, 1); run(10);

        // Async reset while down is mid-debounce and center is held
        pat(V_CENTER, 1); run(8);
        check("pre_rst_center_held", int'(bus.held[BTN_CENTER]), 1);
        pat(V_DOWN | V_CENTER, 1); run(4);
        #2 rst = 1'b1;
        #1;
        check("rst_async_held", int'(bus.held), 0);
        check("rst_async_pulses", int'({bus.center, bus.right, bus.left, bus.down, bus.up}), 0);
        pat(V_DOWN | V_CENTER, 1); run(3);
        check("rst_hold_pulses", sum_pulses(), 0);
        rst = 1'b0;
        pat(V_DOWN | V_CENTER, 1); run(12);
        check("rst_down_idx", pfirst[BTN_DOWN], 5);
        check("rst_down_cnt", pcnt[BTN_DOWN], 1);
        check("rst_center_idx", pfirst[BTN_CENTER], 5);
        pat(V_NONE, 1); run(10);

        // One-cycle glitch and a DEBOUNCE_CYCLES-1 glitch are rejected
        pat(V_RIGHT, 1); pat(V_NONE, 1); run(15);
        check("glitch1_pulses", sum_pulses(), 0);
        check("glitch1_held", hchg[BTN_RIGHT], -1);
        pat(V_UP, 3); pat(V_NONE, 1); run(15);
        check("glitch3_pulses", sum_pulses(), 0);
        check("glitch3_held", int'(bus.held), 0);

        // Exactly DEBOUNCE_CYCLES of high is accepted
        pat(V_UP, 4); pat(V_NONE, 1); run(15);
        check("edge4_up_cnt", pcnt[BTN_UP], 1);
        check("edge4_up_idx", pfirst[BTN_UP], 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
